shared_divider: RTL
===================

SHARED_DIVIDER -- requirements
Module: shared_divider

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits.
REQ-002 The clock and reset scheme SHALL be one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  client 0 division request, level; operands valid and stable while high.
REQ-006 dividend0, divisor0  input  WIDTH each  client 0 operands, unsigned.
REQ-007 req1  input  1  client 1 division request, level.
REQ-008 dividend1, divisor1  input  WIDTH each  client 1 operands, unsigned.
REQ-009 busy  output  1  high while a division is in progress (CALC and DONE).
REQ-010 ready  output  1  one-cycle pulse: quotient/remainder valid.
REQ-011 select  output  1  index of the client owning the current or most recent division.
REQ-012 quotient  output  WIDTH  registered quotient.
REQ-013 remainder  output  WIDTH  registered remainder.
REQ-014 div_by_zero  output  1  registered; set with ready when divisor was 0.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE; all outputs registered.
REQ-016 IDLE: busy=0, ready=0; if req0 or req1 is sampled high, the divider SHALL grant one client, latch its dividend/divisor, update select, clear the iteration counter and enter CALC on that edge (grant edge).
REQ-017 Arbitration: only one requester -> grant it; both high -> grant the client not granted last (round robin); last-grant pointer resets to 1, so client 0 wins the first tie.
REQ-018 CALC: restoring division, one quotient bit per cycle, MSB first, exactly WIDTH cycles; busy=1.
REQ-019 Partial remainder SHALL be WIDTH+1 bits wide to avoid overflow on the trial subtraction.
REQ-020 After the WIDTH-th CALC cycle, the FSM SHALL enter DONE, load quotient/remainder/div_by_zero and assert ready=1, busy=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency: grant edge at cycle 0 -> busy high cycles 1..WIDTH+1 -> ready high in cycle WIDTH+1 (17 for WIDTH=16) -> busy low in cycle WIDTH+2.
REQ-022 Divisor 0: same latency; quotient = all ones, remainder = latched dividend, div_by_zero=1.
REQ-023 div_by_zero SHALL be cleared on the next grant edge.
REQ-024 Requests in CALC/DONE SHALL be ignored; a request still held high is serviced from IDLE, with no back-to-back grant in the DONE cycle.
REQ-025 Operand changes after the grant edge SHALL NOT affect the running division.
REQ-026 quotient, remainder and select SHALL hold their values until the next DONE or grant edge respectively.
REQ-027 Dividend < divisor -> quotient 0, remainder = dividend.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, busy=0, ready=0, select=0, quotient=0, remainder=0, div_by_zero=0, and last-grant pointer=1.
REQ-029 Reset during CALC or DONE SHALL abort the division with no ready pulse, even after rst is released.
REQ-030 After rst falls, a held request SHALL be granted on the first rising edge that samples it.

Verification
REQ-031 req0=1, 1000/7, WIDTH=16 -> select=0, busy rises cycle 1, ready pulse cycle 17, quotient=142, remainder=6, div_by_zero=0.
REQ-032 req1=1, 0xFFFF/1 then 5/9 -> first quotient=0xFFFF, remainder=0; second quotient=0, remainder=5; select=1 both.
REQ-033 req0=1, 1234/0 -> ready cycle 17, quotient=0xFFFF, remainder=1234, div_by_zero=1; next grant clears div_by_zero.
REQ-034 req0 and req1 both held -> grants alternate 0,1,0,1; each result matches its own operands; one idle (busy=0) cycle between divisions.
REQ-035 rst pulsed at CALC cycle 8 -> all outputs 0 immediately, no ready pulse; with req1 held, a new division starts on the first edge after release and completes 17 cycles later.
REQ-036 Operands of the granted client changed at cycle 3 -> result still matches the values latched at the grant edge.

Source files
------------

// File: rtl/shared_divider_if.sv
// ---------------------------------------------------------------------------
// shared_divider_if
//   Bundles the two client request/operand channels and the shared result
//   channel of shared_divider.
//
//   Client side (driven by the clients, read by the divider):
//     req0, dividend0, divisor0   client 0 level request and unsigned operands
//     req1, dividend1, divisor1   client 1 level request and unsigned operands
//   Result side (driven by the divider, read by the clients):
//     busy         division in progress (CALC and DONE)
//     ready        one-cycle pulse, quotient/remainder valid
//     select       client owning the current or most recent division
//     quotient     registered quotient
//     remainder    registered remainder
//     div_by_zero  set together with ready when the divisor was zero
//
//   Modports: master = client/requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface shared_divider_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic [WIDTH-1:0] dividend0;
  logic [WIDTH-1:0] divisor0;
  logic             req1;
  logic [WIDTH-1:0] dividend1;
  logic [WIDTH-1:0] divisor1;

  logic             busy;
  logic             ready;
  logic             select;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output req0, dividend0, divisor0,
    output req1, dividend1, divisor1,
    input  busy, ready, select, quotient, remainder, div_by_zero
  );

  modport slave (
    input  req0, dividend0, divisor0,
    input  req1, dividend1, divisor1,
    output busy, ready, select, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/shared_divider.sv
// ---------------------------------------------------------------------------
// shared_divider
//   One restoring unsigned divider shared by two clients with round-robin
//   arbitration. One quotient bit is produced per cycle, MSB first, so a
//   division takes WIDTH CALC cycles followed by one DONE cycle carrying the
//   ready pulse.
//
//   Ports:
//     clk  rising-edge clock for all state
//     rst  asynchronous, active-high reset (aborts any division in flight)
//     bus  shared_divider_if.slave: client requests/operands in, results out
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module shared_divider #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  shared_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic             last_grant_reg;
  logic             select_reg;
  logic             busy_reg;
  logic             ready_reg;
  logic             div_by_zero_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quo_work_reg;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   rem_work_reg;   // partial remainder, one guard bit
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic             grant_next;
  logic [WIDTH-1:0] dividend_next;
  logic [WIDTH-1:0] divisor_next;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // Arbitration: a lone requester wins; on a tie the client not served last wins.
  always_comb begin
    grant_next = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_next = ~last_grant_reg;
    end else begin
      grant_next = bus.req1;
    end
    dividend_next = grant_next ? bus.dividend1 : bus.dividend0;
    divisor_next  = grant_next ? bus.divisor1  : bus.divisor0;
  end

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = (rem_work_reg << 1) | {{WIDTH{1'b0}}, quo_work_reg[WIDTH-1]};
    fits     = (trial >= {1'b0, divisor_reg});
    rem_next = fits ? (trial - {1'b0, divisor_reg}) : trial;
    quo_next = {quo_work_reg[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      select_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      ready_reg       <= 1'b0;
      div_by_zero_reg <= 1'b0;
      dividend_reg    <= '0;
      divisor_reg     <= '0;
      quo_work_reg    <= '0;
      rem_work_reg    <= '0;
      count_reg       <= '0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
          if (bus.req0 || bus.req1) begin
            select_reg      <= grant_next;
            last_grant_reg  <= grant_next;
            dividend_reg    <= dividend_next;
            divisor_reg     <= divisor_next;
            quo_work_reg    <= dividend_next;
            rem_work_reg    <= '0;
            count_reg       <= '0;
            div_by_zero_reg <= 1'b0;
            busy_reg        <= 1'b1;
            state_reg       <= CALC;
          end
        end

        CALC: begin
          busy_reg     <= 1'b1;
          rem_work_reg <= rem_next;
          quo_work_reg <= quo_next;
          count_reg    <= count_reg + CW'(1);
          if (count_reg == LAST_STEP) begin
            // Final step: publish the result straight from this step's output.
            state_reg <= DONE;
            ready_reg <= 1'b1;
            if (divisor_reg == '0) begin
              quotient_reg    <= '1;
              remainder_reg   <= dividend_reg;
              div_by_zero_reg <= 1'b1;
            end else begin
              quotient_reg    <= quo_next;
              remainder_reg   <= WIDTH'(rem_next);
              div_by_zero_reg <= 1'b0;
            end
          end
        end

        DONE: begin
          // Requests are not sampled here, forcing one idle cycle between jobs.
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.ready       = ready_reg;
  assign bus.select      = select_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule
